// File: rtl/sisc_ifetch_queue_if.sv
// rtl/sisc_ifetch_queue_if.sv - fetch-stage bundle: imem req/gnt/rvalid, IR valid/ready, flush/halt
// Ports (grouped signals):
//   imem_req, imem_addr            fetch request and address (driven by fetch stage)
//   imem_gnt, imem_rvalid, imem_rdata  memory grant and in-order read response
//   ir_valid, ir_data, ir_pc       IR queue head towards execute
//   ir_ready                       execute pops head
//   flush, flush_pc                branch redirect
//   halt                           stop issuing new fetches
//   qcount                         IR queue occupancy
// Modports: master = fetch stage, slave = memory/execute side.
interface sisc_ifetch_queue_if #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
);
    logic                imem_req;
    logic [ADDRSIZE-1:0] imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [WIDTH-1:0]    imem_rdata;
    logic                ir_valid;
    logic [WIDTH-1:0]    ir_data;
    logic [ADDRSIZE-1:0] ir_pc;
    logic                ir_ready;
    logic                flush;
    logic [ADDRSIZE-1:0] flush_pc;
    logic                halt;
    logic [2:0]          qcount;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_data, ir_pc, qcount,
        input  imem_gnt, imem_rvalid, imem_rdata, ir_ready, flush, flush_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_data, ir_pc, qcount,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready, flush, flush_pc, halt
    );
endinterface

// File: rtl/sisc_ifetch_queue.sv
// rtl/sisc_ifetch_queue.sv - SISC instruction fetch stage with PC, in-order fetch and IR queue
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    master modport of sisc_ifetch_queue_if (imem request/response, IR head,
//          flush/flush_pc, halt, qcount)
module sisc_ifetch_queue #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int QDEPTH   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    sisc_ifetch_queue_if.master    bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [ADDRSIZE-1:0] pc;
    logic [PW-1:0]       head, tail;
    logic [2:0]          qcount;
    logic [2:0]          outstanding;
    logic [2:0]          drop;

    logic [WIDTH-1:0]    q_data [QDEPTH];
    logic [ADDRSIZE-1:0] q_pc   [QDEPTH];

    // Addresses of issued-but-unanswered fetches, oldest first. Its occupancy always
    // equals outstanding, so dropped responses after a flush still pop their tag.
    logic [ADDRSIZE-1:0] tag_pc [QDEPTH];
    logic [PW-1:0]       tag_wr, tag_rd;

    logic [3:0] credit_used;
    logic       issue, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queued words plus in-flight fetches never exceed QDEPTH, so a response
    // always finds a free slot.
    assign credit_used = {1'b0, qcount} + {1'b0, outstanding};
    assign bus.imem_req  = !reset && !bus.halt && !bus.flush && (credit_used < 4'(QDEPTH));
    assign bus.imem_addr = pc;

    assign issue = bus.imem_req && bus.imem_gnt;
    assign push  = bus.imem_rvalid && (drop == 3'd0) && !bus.flush;
    assign pop   = bus.ir_valid && bus.ir_ready && !bus.flush;

    assign bus.ir_valid = (qcount != 3'd0);
    assign bus.ir_data  = q_data[head];
    assign bus.ir_pc    = q_pc[head];
    assign bus.qcount   = qcount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            head        <= '0;
            tail        <= '0;
            qcount      <= '0;
            outstanding <= '0;
            drop        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
                tag_pc[i] <= '0;
            end
        end else begin
            if (issue) begin
                pc             <= pc + 1'b1;
                tag_pc[tag_wr] <= pc;
                tag_wr         <= ptr_inc(tag_wr);
            end
            if (bus.imem_rvalid) begin
                tag_rd <= ptr_inc(tag_rd);
            end

            if (bus.flush) begin
                // Every fetch still in flight becomes stale; the one answering
                // this cycle is already gone.
                pc          <= bus.flush_pc;
                head        <= '0;
                tail        <= '0;
                qcount      <= '0;
                drop        <= outstanding - {2'b0, bus.imem_rvalid};
                outstanding <= outstanding - {2'b0, bus.imem_rvalid};
            end else begin
                if (push) begin
                    q_data[tail] <= bus.imem_rdata;
                    q_pc[tail]   <= tag_pc[tag_rd];
                    tail         <= ptr_inc(tail);
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                if (bus.imem_rvalid && (drop != 3'd0)) begin
                    drop <= drop - 3'd1;
                end
                qcount      <= qcount + {2'b0, push} - {2'b0, pop};
                outstanding <= outstanding + {2'b0, issue} - {2'b0, bus.imem_rvalid};
            end
        end
    end

    // A response with nothing in flight means the memory broke the protocol.
    always_ff @(posedge clock) begin
        if (!reset && bus.imem_rvalid) begin
            assert (outstanding != 3'd0)
            else $error("sisc_ifetch_queue: imem_rvalid with no outstanding fetch");
        end
    end
endmodule

// File: tb/tb_sisc_ifetch_queue.sv
// tb/tb_sisc_ifetch_queue.sv - randomized self-checking bench for sisc_ifetch_queue
module tb_sisc_ifetch_queue;
    logic clock = 1'b0;
    logic reset = 1'b1;

    sisc_ifetch_queue_if #(.WIDTH(32), .ADDRSIZE(12)) bus ();

    sisc_ifetch_queue #(.WIDTH(32), .ADDRSIZE(12), .QDEPTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Memory environment: fixed latency per test, in-order responses.
    typedef struct { logic [11:0] a; int due; } mreq_t;
    mreq_t pend[$];
    int    lat    = 1;
    int    edge_n = 0;
    logic [31:0] salt = 32'h0;

    // Reference model: PC, list of queued instruction addresses, list of in-flight fetches.
    typedef struct { logic [11:0] a; bit stale; } fl_t;
    logic [11:0] m_pc;
    logic [11:0] mq[$];
    fl_t         infl[$];

    logic        exp_req;
    logic [60:0] exp_obs;
    logic [60:0] obs;

    function automatic logic [31:0] mem(input logic [11:0] a);
        return 32'(a) ^ salt;
    endfunction

    function automatic logic [60:0] dut_obs();
        return {bus.imem_req, bus.imem_req ? bus.imem_addr : 12'h0,
                bus.ir_valid, bus.ir_valid ? bus.ir_pc : 12'h0,
                bus.ir_valid ? bus.ir_data : 32'h0, bus.qcount};
    endfunction

    task automatic model_clear();
        pend.delete();
        mq.delete();
        infl.delete();
        m_pc = 12'h0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.flush       = 1'b0;
        bus.flush_pc    = 12'h0;
        bus.halt        = 1'b0;
        bus.ir_ready    = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a negedge: drive this cycle's inputs and compute expected outputs.
    task automatic drive(input bit f, input logic [11:0] fpc, input bit h, input bit rdy, input bit g);
        bus.flush    = f;
        bus.flush_pc = fpc;
        bus.halt     = h;
        bus.ir_ready = rdy;
        bus.imem_gnt = g;
        if (pend.size() > 0 && pend[0].due <= edge_n + 1) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem(pend[0].a);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        exp_req = !h && !f && (mq.size() + infl.size() < 3);
        exp_obs = {exp_req, exp_req ? m_pc : 12'h0,
                   mq.size() > 0, mq.size() > 0 ? mq[0] : 12'h0,
                   mq.size() > 0 ? mem(mq[0]) : 32'h0, 3'(mq.size())};
    endtask

    // Apply the clock edge to model and memory, return at the next negedge.
    task automatic advance();
        bit          issue_d, issue_m, rv, pop;
        logic [11:0] addr_d;
        fl_t         r;
        mreq_t       n;
        r       = '{a: 12'h0, stale: 1'b1};
        issue_d = bus.imem_req && bus.imem_gnt;
        addr_d  = bus.imem_addr;
        rv      = bus.imem_rvalid;
        issue_m = exp_req && bus.imem_gnt;
        pop     = (mq.size() > 0) && bus.ir_ready;
        if (rv && infl.size() > 0) r = infl.pop_front();
        if (bus.flush) begin
            foreach (infl[i]) infl[i].stale = 1'b1;
            mq.delete();
            m_pc = bus.flush_pc;
        end else begin
            if (pop) void'(mq.pop_front());
            if (rv && !r.stale) mq.push_back(r.a);
            if (issue_m) begin
                infl.push_back('{a: m_pc, stale: 1'b0});
                m_pc = m_pc + 12'h1;
            end
        end
        @(posedge clock);
        edge_n++;
        if (rv && pend.size() > 0) void'(pend.pop_front());
        if (issue_d) begin
            n.a   = addr_d;
            n.due = edge_n + lat;
            pend.push_back(n);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [60:0] raw;
        reset = 1'b1;
        bus.flush = 0; bus.flush_pc = 0; bus.halt = 0; bus.ir_ready = 0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        model_clear();
        #1;
        raw = {bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_pc, bus.ir_data, bus.qcount};
        tests++;
        if (raw !== 61'h0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", raw); end
        @(negedge clock);
        reset = 1'b0;
        lat = 1; salt = 32'h0;
        drive(0, 0, 0, 0, 1);
        tests++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 12'h000}) begin
            fails++; $display("FAIL reset_release req/addr got=%b/%h exp=1/000", bus.imem_req, bus.imem_addr);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) drive(0, 0, 0, 0, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL reset_prefill c%0d got=%h exp=%h", c, obs, exp_obs); end
            advance();
        end
        // Asynchronous reset in the middle of a cycle with a full queue.
        #2;
        reset = 1'b1;
        bus.imem_rvalid = 1'b0;
        #1;
        raw = {bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_pc, bus.ir_data, bus.qcount};
        tests++;
        if (raw !== 61'h0) begin fails++; $display("FAIL reset_midcycle got=%h exp=0", raw); end
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, 1, 1);
        tests++;
        if ({bus.imem_req, bus.imem_addr, bus.qcount} !== {1'b1, 12'h000, 3'd0}) begin
            fails++; $display("FAIL reset_restart req/addr/qcount got=%b/%h/%0d exp=1/000/0",
                              bus.imem_req, bus.imem_addr, bus.qcount);
        end
        advance();
    endtask

    task automatic test_stream();
        int first = -1;
        int maxq  = 0;
        logic [11:0] nextpc = 12'h0;
        lat = 1; salt = 32'h0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive(0, 0, 0, 1, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL stream c%0d got=%h exp=%h", c, obs, exp_obs); end
            if (int'(bus.qcount) > maxq) maxq = int'(bus.qcount);
            if (bus.ir_valid) begin
                if (first < 0) first = c;
                tests++;
                if ({bus.ir_pc, bus.ir_data} !== {nextpc, 32'(nextpc)}) begin
                    fails++; $display("FAIL stream_seq pc/data got=%h/%h exp=%h/%h", bus.ir_pc, bus.ir_data, nextpc, 32'(nextpc));
                end
                nextpc = nextpc + 12'h1;
            end
            advance();
        end
        tests++;
        if (first != 2) begin fails++; $display("FAIL stream_latency got=%0d exp=2", first); end
        tests++;
        if (maxq > 1 || nextpc != 12'd22) begin
            fails++; $display("FAIL stream_rate maxq=%0d words=%0d exp maxq<=1 words=22", maxq, nextpc);
        end
    endtask

    task automatic test_backpressure();
        int issues = 0;
        logic [35:0] addrs = 36'h0;
        lat = 1; salt = 32'h0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 0, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL bp c%0d got=%h exp=%h", c, obs, exp_obs); end
            if (bus.imem_req && issues < 3) addrs[issues*12 +: 12] = bus.imem_addr;
            if (bus.imem_req) issues++;
            advance();
        end
        tests++;
        if (issues != 3 || addrs !== {12'd2, 12'd1, 12'd0}) begin
            fails++; $display("FAIL bp_issues got=%0d addrs=%h exp=3 addrs=002001000", issues, addrs);
        end
        drive(0, 0, 0, 0, 1);
        tests++;
        if ({bus.qcount, bus.imem_req, bus.ir_data} !== {3'd3, 1'b0, 32'h0}) begin
            fails++; $display("FAIL bp_full qcount/req/data got=%0d/%b/%h exp=3/0/0", bus.qcount, bus.imem_req, bus.ir_data);
        end
        advance();
        drive(0, 0, 0, 1, 1);
        advance();
        drive(0, 0, 0, 0, 1);
        tests++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 12'h003}) begin
            fails++; $display("FAIL bp_refill req/addr got=%b/%h exp=1/003", bus.imem_req, bus.imem_addr);
        end
        advance();
        drive(0, 0, 0, 0, 1);
        obs = dut_obs(); tests++;
        if (obs !== exp_obs) begin fails++; $display("FAIL bp_after got=%h exp=%h", obs, exp_obs); end
        advance();
    endtask

    task automatic test_flush();
        bit seen = 0;
        lat = 3; salt = 32'hABCDE000;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL flush_pre c%0d got=%h exp=%h", c, obs, exp_obs); end
            advance();
        end
        drive(1, 12'h100, 0, 0, 1);
        obs = dut_obs(); tests++;
        if (obs !== exp_obs) begin fails++; $display("FAIL flush_cycle got=%h exp=%h", obs, exp_obs); end
        advance();
        for (int c = 0; c < 20 && !seen; c++) begin
            drive(0, 0, 0, 0, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL flush_post c%0d got=%h exp=%h", c, obs, exp_obs); end
            if (bus.ir_valid) begin
                seen = 1;
                tests++;
                if ({bus.ir_pc, bus.ir_data} !== {12'h100, mem(12'h100)}) begin
                    fails++; $display("FAIL flush_target pc/data got=%h/%h exp=100/%h", bus.ir_pc, bus.ir_data, mem(12'h100));
                end
            end
            advance();
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL flush_timeout got=no_valid exp=valid"); end
    endtask

    task automatic test_flush_pop_rvalid();
        bit done = 0;
        bit seen = 0;
        lat = 2; salt = 32'h13579000;
        do_reset();
        for (int c = 0; c < 16 && !done; c++) begin
            bit f;
            f = (c >= 4) && (pend.size() > 0 && pend[0].due <= edge_n + 1) && (mq.size() > 0);
            drive(f, 12'h2A0, 0, 1, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL fpr c%0d got=%h exp=%h", c, obs, exp_obs); end
            advance();
            if (f) begin
                done = 1;
                drive(0, 0, 0, 1, 1);
                tests++;
                if ({bus.qcount, bus.ir_valid} !== {3'd0, 1'b0}) begin
                    fails++; $display("FAIL fpr_empty qcount/valid got=%0d/%b exp=0/0", bus.qcount, bus.ir_valid);
                end
                advance();
            end
        end
        tests++;
        if (!done) begin fails++; $display("FAIL fpr_setup got=no_overlap exp=overlap"); end
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, 1, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL fpr_post c%0d got=%h exp=%h", c, obs, exp_obs); end
            if (bus.ir_valid && !seen) begin
                seen = 1; tests++;
                if (bus.ir_pc !== 12'h2A0) begin fails++; $display("FAIL fpr_target got=%h exp=2a0", bus.ir_pc); end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [11:0] nextpc = 12'hFFF;
        int words = 0;
        lat = 1; salt = 32'h2468A000;
        do_reset();
        drive(1, 12'hFFF, 0, 1, 1);
        advance();
        for (int c = 0; c < 30; c++) begin
            bit h;
            h = (c >= 8 && c < 11);
            drive(0, 0, h, 1, 1);
            obs = dut_obs(); tests++;
            if (obs !== exp_obs) begin fails++; $display("FAIL wrap c%0d got=%h exp=%h", c, obs, exp_obs); end
            if (bus.ir_valid) begin
                tests++;
                if (bus.ir_pc !== nextpc) begin fails++; $display("FAIL wrap_seq got=%h exp=%h", bus.ir_pc, nextpc); end
                nextpc = nextpc + 12'h1;
                words++;
            end
            advance();
        end
        tests++;
        if (words < 20) begin fails++; $display("FAIL wrap_progress got=%0d exp>=20", words); end
    endtask

    task automatic test_random();
        for (int s = 1; s <= 3; s++) begin
            lat  = s;
            salt = $urandom & 32'hFFFFF000;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                drive(($urandom % 16) == 0, 12'($urandom), ($urandom % 8) == 0,
                      ($urandom % 3) != 0, ($urandom % 4) != 0);
                obs = dut_obs(); tests++;
                if (obs !== exp_obs) begin fails++; $display("FAIL random lat%0d c%0d got=%h exp=%h", s, c, obs, exp_obs); end
                advance();
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_pop_rvalid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
